// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the memory stage
package mem_stage_pkg;

    localparam int XLEN = 32;

    // mem_opcode[1:0] is the access size, mem_opcode[2] selects zero-extension on loads
    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;
    localparam int         MEM_OP_UNSIGNED_BIT = 2;

    typedef enum logic [1:0] {
        MS_IDLE  = 2'd0,
        MS_REQ   = 2'd1,
        MS_RESP  = 2'd2,
        MS_DRAIN = 2'd3
    } mem_state_e;

    typedef struct packed {
        logic valid;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic csr_read;
        logic csr_write;
        logic mret;
    } ex2mem_pipeline_ctrl_t;

    typedef struct packed {
        logic illegal_instruction;
        logic ecall;
        logic ebreak;
    } ex2mem_pipeline_exc_t;

    typedef struct packed {
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] mem_writedata;
        logic [2:0]      mem_opcode;
        logic [4:0]      reg_regid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instruction;
    } ex2mem_pipeline_data_t;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic csr_read;
        logic csr_write;
        logic mret;
    } mem2wb_pipeline_ctrl_t;

    typedef struct packed {
        logic illegal_instruction;
        logic ecall;
        logic ebreak;
        logic exception_load_addr_misaligned;
        logic exception_store_addr_misaligned;
    } mem2wb_pipeline_exc_t;

    typedef struct packed {
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] reg_writedata;
        logic [4:0]      reg_regid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instruction;
    } mem2wb_pipeline_data_t;

    // Halfwords must sit on even addresses, words on multiples of four
    function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == MEM_SIZE_HALF) && addr_lo[0]) ||
               ((size == MEM_SIZE_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data bus between the memory stage and the memory system
interface mem_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();
    logic [ADDR_W-1:0]   dbus_address;
    logic                dbus_read;
    logic                dbus_write;
    logic [DATA_W/8-1:0] dbus_byteenable;
    logic [DATA_W-1:0]   dbus_writedata;
    logic                dbus_waitrequest;
    logic                dbus_readdatavalid;
    logic [DATA_W-1:0]   dbus_readdata;

    modport master (
        output dbus_address, dbus_read, dbus_write, dbus_byteenable, dbus_writedata,
        input  dbus_waitrequest, dbus_readdatavalid, dbus_readdata
    );

    modport slave (
        input  dbus_address, dbus_read, dbus_write, dbus_byteenable, dbus_writedata,
        output dbus_waitrequest, dbus_readdatavalid, dbus_readdata
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane enables, store replication, load extraction and extension
module lsu_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]          addr_lo_i,
    input  logic [1:0]          size_i,
    input  logic                unsigned_i,
    input  logic [DATA_W-1:0]   store_data_i,
    input  logic [DATA_W-1:0]   load_data_i,
    output logic [DATA_W/8-1:0] byteenable_o,
    output logic [DATA_W-1:0]   store_data_o,
    output logic [DATA_W-1:0]   load_data_o
);
    localparam int NB = DATA_W / 8;

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Pick the addressed lane(s) from the bus word
    assign load_byte = load_data_i[{addr_lo_i, 3'b000} +: 8];
    assign load_half = load_data_i[{addr_lo_i[1], 4'b0000} +: 16];

    // Lane mask, replicated store data and extended load data per access size
    always_comb begin
        byteenable_o = {NB{1'b1}};
        store_data_o = store_data_i;
        load_data_o  = load_data_i;
        case (size_i)
            MEM_SIZE_BYTE: begin
                byteenable_o = NB'(1) << addr_lo_i;
                store_data_o = {NB{store_data_i[7:0]}};
                load_data_o  = {{(DATA_W-8){load_byte[7] & ~unsigned_i}}, load_byte};
            end
            MEM_SIZE_HALF: begin
                byteenable_o = NB'(3) << addr_lo_i;
                store_data_o = {(NB/2){store_data_i[15:0]}};
                load_data_o  = {{(DATA_W-16){load_half[15] & ~unsigned_i}}, load_half};
            end
            default: begin
                byteenable_o = {NB{1'b1}};
                store_data_o = store_data_i;
                load_data_o  = load_data_i;
            end
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: data bus sequencing and MEM/WB register
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_flush,
    input  ex2mem_pipeline_ctrl_t ex2mem_pipeline_ctrl,
    input  ex2mem_pipeline_exc_t  ex2mem_pipeline_exc,
    input  ex2mem_pipeline_data_t ex2mem_pipeline_data,
    mem_stage_if.master           dbus,
    output logic                  mem_stall_req,
    output mem2wb_pipeline_ctrl_t mem2wb_pipeline_ctrl,
    output mem2wb_pipeline_exc_t  mem2wb_pipeline_exc,
    output mem2wb_pipeline_data_t mem2wb_pipeline_data
);
    mem_state_e state_q, state_d;

    logic [1:0]        size;
    logic [1:0]        addr_lo;
    logic              is_load, is_store, is_mem, misaligned;
    logic              in_issue, access, accepted;
    logic              complete, stall;
    logic [DATA_W-1:0] load_ext;

    assign size       = ex2mem_pipeline_data.mem_opcode[1:0];
    assign addr_lo    = ex2mem_pipeline_data.alu_out[1:0];
    assign is_load    = ex2mem_pipeline_ctrl.valid & ex2mem_pipeline_ctrl.mem_read;
    assign is_store   = ex2mem_pipeline_ctrl.valid & ex2mem_pipeline_ctrl.mem_write
                      & ~ex2mem_pipeline_ctrl.mem_read;
    assign is_mem     = is_load | is_store;
    assign misaligned = addr_misaligned(size, addr_lo);
    assign in_issue   = (state_q == MS_IDLE) || (state_q == MS_REQ);
    assign access     = in_issue & is_mem & ~misaligned & ~mem_flush;
    assign accepted   = access & ~dbus.dbus_waitrequest;

    // Strobes are forced low during reset so a stale state cannot leak a request
    assign dbus.dbus_read    = access & is_load & ~rst;
    assign dbus.dbus_write   = access & is_store & ~rst;
    assign dbus.dbus_address = {ex2mem_pipeline_data.alu_out[ADDR_W-1:2], 2'b00};
    assign mem_stall_req     = stall & ~rst;

    lsu_align #(.DATA_W(DATA_W)) u_lsu_align (
        .addr_lo_i    (addr_lo),
        .size_i       (size),
        .unsigned_i   (ex2mem_pipeline_data.mem_opcode[MEM_OP_UNSIGNED_BIT]),
        .store_data_i (ex2mem_pipeline_data.mem_writedata),
        .load_data_i  (dbus.dbus_readdata),
        .byteenable_o (dbus.dbus_byteenable),
        .store_data_o (dbus.dbus_writedata),
        .load_data_o  (load_ext)
    );

    // Next state, stall request and completion of the instruction held in EX/MEM
    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        complete = 1'b0;
        case (state_q)
            MS_IDLE, MS_REQ: begin
                if (access) begin
                    if (accepted && is_load) begin
                        state_d = MS_RESP;
                        stall   = 1'b1;
                    end else if (accepted) begin
                        state_d  = MS_IDLE;
                        complete = 1'b1;
                    end else begin
                        state_d = MS_REQ;
                        stall   = 1'b1;
                    end
                end else begin
                    // Non-memory ops and misaligned accesses retire here; a flush kills it
                    state_d  = MS_IDLE;
                    complete = ex2mem_pipeline_ctrl.valid & ~mem_flush;
                end
            end
            MS_RESP: begin
                if (dbus.dbus_readdatavalid) begin
                    state_d  = MS_IDLE;
                    complete = ~mem_flush;
                end else begin
                    stall = 1'b1;
                    if (mem_flush) begin
                        state_d = MS_DRAIN;
                    end
                end
            end
            MS_DRAIN: begin
                stall = 1'b1;
                if (dbus.dbus_readdatavalid) begin
                    state_d = MS_IDLE;
                end
            end
            default: begin
                state_d = MS_IDLE;
            end
        endcase
    end

    // Bus sequencing state; reset abandons any outstanding response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // MEM/WB control and exceptions: results on completion, bubble otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            mem2wb_pipeline_ctrl <= '0;
            mem2wb_pipeline_exc  <= '0;
        end else if (complete) begin
            mem2wb_pipeline_ctrl.valid     <= 1'b1;
            mem2wb_pipeline_ctrl.reg_write <= ex2mem_pipeline_ctrl.reg_write;
            mem2wb_pipeline_ctrl.csr_read  <= ex2mem_pipeline_ctrl.csr_read;
            mem2wb_pipeline_ctrl.csr_write <= ex2mem_pipeline_ctrl.csr_write;
            mem2wb_pipeline_ctrl.mret      <= ex2mem_pipeline_ctrl.mret;
            mem2wb_pipeline_exc.illegal_instruction            <= ex2mem_pipeline_exc.illegal_instruction;
            mem2wb_pipeline_exc.ecall                          <= ex2mem_pipeline_exc.ecall;
            mem2wb_pipeline_exc.ebreak                         <= ex2mem_pipeline_exc.ebreak;
            mem2wb_pipeline_exc.exception_load_addr_misaligned <= is_load & misaligned;
            mem2wb_pipeline_exc.exception_store_addr_misaligned <= is_store & misaligned;
        end else begin
            mem2wb_pipeline_ctrl <= '0;
            mem2wb_pipeline_exc  <= '0;
        end
    end

    // MEM/WB payload is only meaningful alongside valid, so it is not reset
    always_ff @(posedge clk) begin
        if (complete) begin
            mem2wb_pipeline_data.alu_out       <= ex2mem_pipeline_data.alu_out;
            mem2wb_pipeline_data.reg_writedata <= is_load ? load_ext : ex2mem_pipeline_data.alu_out;
            mem2wb_pipeline_data.reg_regid     <= ex2mem_pipeline_data.reg_regid;
            mem2wb_pipeline_data.pc            <= ex2mem_pipeline_data.pc;
            mem2wb_pipeline_data.instruction   <= ex2mem_pipeline_data.instruction;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk;
    logic rst;
    logic mem_flush;
    logic mem_stall_req;
    ex2mem_pipeline_ctrl_t ex_ctrl;
    ex2mem_pipeline_exc_t  ex_exc;
    ex2mem_pipeline_data_t ex_data;
    mem2wb_pipeline_ctrl_t wb_ctrl;
    mem2wb_pipeline_exc_t  wb_exc;
    mem2wb_pipeline_data_t wb_data;

    int tests = 0;
    int fails = 0;
    int stall_cnt;

    mem_stage_if #(.DATA_W(32), .ADDR_W(32)) dbus ();

    mem_stage #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .mem_flush            (mem_flush),
        .ex2mem_pipeline_ctrl (ex_ctrl),
        .ex2mem_pipeline_exc  (ex_exc),
        .ex2mem_pipeline_data (ex_data),
        .dbus                 (dbus),
        .mem_stall_req        (mem_stall_req),
        .mem2wb_pipeline_ctrl (wb_ctrl),
        .mem2wb_pipeline_exc  (wb_exc),
        .mem2wb_pipeline_data (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        ex_ctrl = '0;
        ex_exc  = '0;
        ex_data = '0;
    endtask

    task automatic set_load(input logic [31:0] addr, input logic [2:0] op);
        set_idle();
        ex_ctrl.valid      = 1'b1;
        ex_ctrl.mem_read   = 1'b1;
        ex_ctrl.reg_write  = 1'b1;
        ex_data.alu_out    = addr;
        ex_data.mem_opcode = op;
        ex_data.reg_regid  = 5'd7;
    endtask

    task automatic set_store(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] op);
        set_idle();
        ex_ctrl.valid         = 1'b1;
        ex_ctrl.mem_write     = 1'b1;
        ex_data.alu_out       = addr;
        ex_data.mem_writedata = wd;
        ex_data.mem_opcode    = op;
    endtask

    initial begin
        rst = 1'b1;
        mem_flush = 1'b0;
        set_idle();
        dbus.dbus_waitrequest   = 1'b0;
        dbus.dbus_readdatavalid = 1'b0;
        dbus.dbus_readdata      = '0;
        tick();
        tick();

        // Reset state, with a load presented to show strobes stay quiet
        set_load(32'h100, 3'b010);
        #1;
        chk("rst_ctrl", 32'(wb_ctrl), 32'h0);
        chk("rst_exc", 32'(wb_exc), 32'h0);
        chk("rst_read", 32'(dbus.dbus_read), 32'h0);
        chk("rst_write", 32'(dbus.dbus_write), 32'h0);
        chk("rst_stall", 32'(mem_stall_req), 32'h0);
        chk("rst_state", 32'(dut.state_q), 32'(MS_IDLE));
        rst = 1'b0;
        set_idle();
        tick();

        // LW 0x100, accepted at once, data one cycle later
        set_load(32'h100, 3'b010);
        #1;
        chk("lw_read", 32'(dbus.dbus_read), 32'h1);
        chk("lw_addr", dbus.dbus_address, 32'h100);
        chk("lw_be", 32'(dbus.dbus_byteenable), 32'hF);
        chk("lw_stall", 32'(mem_stall_req), 32'h1);
        tick();
        chk("lw_bubble", 32'(wb_ctrl.valid), 32'h0);
        chk("lw_state_resp", 32'(dut.state_q), 32'(MS_RESP));
        dbus.dbus_readdatavalid = 1'b1;
        dbus.dbus_readdata = 32'hDEADBEEF;
        #1;
        chk("lw_read_resp", 32'(dbus.dbus_read), 32'h0);
        chk("lw_stall_rdv", 32'(mem_stall_req), 32'h0);
        tick();
        chk("lw_valid", 32'(wb_ctrl.valid), 32'h1);
        chk("lw_data", wb_data.reg_writedata, 32'hDEADBEEF);
        chk("lw_regid", 32'(wb_data.reg_regid), 32'h7);
        dbus.dbus_readdatavalid = 1'b0;
        set_idle();

        // LB / LBU from the top byte lane
        set_load(32'h103, 3'b000);
        #1;
        chk("lb_be", 32'(dbus.dbus_byteenable), 32'h8);
        chk("lb_addr", dbus.dbus_address, 32'h100);
        tick();
        dbus.dbus_readdatavalid = 1'b1;
        dbus.dbus_readdata = 32'h80112233;
        tick();
        chk("lb_data", wb_data.reg_writedata, 32'hFFFFFF80);
        dbus.dbus_readdatavalid = 1'b0;
        set_load(32'h103, 3'b100);
        #1;
        tick();
        dbus.dbus_readdatavalid = 1'b1;
        tick();
        chk("lbu_data", wb_data.reg_writedata, 32'h00000080);
        dbus.dbus_readdatavalid = 1'b0;
        set_idle();

        // SH 0x202 held off by waitrequest for three cycles
        set_store(32'h202, 32'h0000ABCD, 3'b001);
        dbus.dbus_waitrequest = 1'b1;
        stall_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dbus.dbus_waitrequest = 1'b0;
            #1;
            chk("sh_write", 32'(dbus.dbus_write), 32'h1);
            chk("sh_addr", dbus.dbus_address, 32'h200);
            chk("sh_be", 32'(dbus.dbus_byteenable), 32'hC);
            chk("sh_wdata", dbus.dbus_writedata, 32'hABCDABCD);
            if (mem_stall_req) stall_cnt++;
            tick();
            if (i < 3) chk("sh_bubble", 32'(wb_ctrl.valid), 32'h0);
        end
        chk("sh_stall_cycles", 32'(stall_cnt), 32'd3);
        chk("sh_valid", 32'(wb_ctrl.valid), 32'h1);
        set_idle();

        // SB 0x201: single lane, byte replicated, no stall
        set_store(32'h201, 32'h000000EF, 3'b000);
        #1;
        chk("sb_be", 32'(dbus.dbus_byteenable), 32'h2);
        chk("sb_wdata", dbus.dbus_writedata, 32'hEFEFEFEF);
        chk("sb_stall", 32'(mem_stall_req), 32'h0);
        tick();
        chk("sb_valid", 32'(wb_ctrl.valid), 32'h1);
        set_idle();

        // Misaligned LW and SH: no bus request, exception recorded
        set_load(32'h101, 3'b010);
        #1;
        chk("lwmis_read", 32'(dbus.dbus_read), 32'h0);
        chk("lwmis_stall", 32'(mem_stall_req), 32'h0);
        tick();
        chk("lwmis_valid", 32'(wb_ctrl.valid), 32'h1);
        chk("lwmis_exc", 32'(wb_exc.exception_load_addr_misaligned), 32'h1);
        set_store(32'h203, 32'h1234, 3'b001);
        #1;
        chk("shmis_write", 32'(dbus.dbus_write), 32'h0);
        tick();
        chk("shmis_exc", 32'(wb_exc), 32'h1);
        set_idle();

        // Non-memory op completes in one cycle; stray readdatavalid in IDLE ignored
        ex_ctrl.valid = 1'b1;
        ex_ctrl.reg_write = 1'b1;
        ex_data.alu_out = 32'h000055AA;
        dbus.dbus_readdatavalid = 1'b1;
        dbus.dbus_readdata = 32'hCAFEF00D;
        #1;
        chk("alu_stall", 32'(mem_stall_req), 32'h0);
        tick();
        chk("alu_valid", 32'(wb_ctrl.valid), 32'h1);
        chk("alu_data", wb_data.reg_writedata, 32'h000055AA);
        chk("alu_state", 32'(dut.state_q), 32'(MS_IDLE));
        dbus.dbus_readdatavalid = 1'b0;
        set_idle();

        // Flush in IDLE drops the request
        set_load(32'h100, 3'b010);
        mem_flush = 1'b1;
        #1;
        chk("flidle_read", 32'(dbus.dbus_read), 32'h0);
        tick();
        chk("flidle_bubble", 32'(wb_ctrl.valid), 32'h0);
        mem_flush = 1'b0;
        set_idle();

        // Flush in RESP drains the outstanding response
        set_load(32'h100, 3'b010);
        #1;
        tick();
        mem_flush = 1'b1;
        #1;
        chk("drain_stall_resp", 32'(mem_stall_req), 32'h1);
        tick();
        chk("drain_state", 32'(dut.state_q), 32'(MS_DRAIN));
        chk("drain_bubble0", 32'(wb_ctrl.valid), 32'h0);
        mem_flush = 1'b0;
        set_idle();
        #1;
        chk("drain_stall1", 32'(mem_stall_req), 32'h1);
        tick();
        chk("drain_state1", 32'(dut.state_q), 32'(MS_DRAIN));
        dbus.dbus_readdatavalid = 1'b1;
        dbus.dbus_readdata = 32'h12345678;
        #1;
        chk("drain_stall_rdv", 32'(mem_stall_req), 32'h1);
        tick();
        chk("drain_idle", 32'(dut.state_q), 32'(MS_IDLE));
        chk("drain_bubble", 32'(wb_ctrl.valid), 32'h0);
        dbus.dbus_readdatavalid = 1'b0;
        #1;
        chk("drain_release", 32'(mem_stall_req), 32'h0);

        // Reset while waiting for a response
        set_load(32'h100, 3'b010);
        #1;
        tick();
        chk("rstresp_state", 32'(dut.state_q), 32'(MS_RESP));
        rst = 1'b1;
        #1;
        chk("rstresp_read", 32'(dbus.dbus_read), 32'h0);
        chk("rstresp_stall", 32'(mem_stall_req), 32'h0);
        tick();
        chk("rstresp_idle", 32'(dut.state_q), 32'(MS_IDLE));
        chk("rstresp_ctrl", 32'(wb_ctrl), 32'h0);
        rst = 1'b0;
        set_idle();
        #1;
        chk("rstresp_write", 32'(dbus.dbus_write), 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, 32, data bus and register width.
REQ-002 SHALL have parameter ADDR_W, 32, data bus address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_flush  input  1  hazard-unit kill of the instruction in MEM.
REQ-006 SHALL have port ex2mem_pipeline_ctrl / _exc / _data  input  struct  EX/MEM register contents (valid, mem_read, mem_write, reg_write, csr_*, mret, alu_out, mem_writedata, mem_opcode, reg_regid, pc, instruction).
REQ-007 SHALL have port dbus_address  output  ADDR_W  word-aligned address, alu_out with [1:0] forced to 0.
REQ-008 SHALL have ports dbus_read, dbus_write  output  1 each  request strobes.
REQ-009 SHALL have port dbus_byteenable  output  DATA_W/8  lane mask.
REQ-010 SHALL have port dbus_writedata  output  DATA_W  lane-shifted store data.
REQ-011 SHALL have ports dbus_waitrequest, dbus_readdatavalid  input  1 each, and dbus_readdata  input  DATA_W.
REQ-012 SHALL have port mem_stall_req  output  1  freeze IF..EX and hold EX/MEM register.
REQ-013 SHALL have ports mem2wb_pipeline_ctrl / _exc / _data  output  struct  MEM/WB register (adds reg_writedata, exception_load_addr_misaligned, exception_store_addr_misaligned).

Function
REQ-014 SHALL decode mem_opcode as: [1:0] size (0 byte, 1 half, 2 word), [2] unsigned load.
REQ-015 SHALL flag a misaligned access when half with addr[0]=1, or word with addr[1:0]!=0; the access then issues no bus request and sets the matching exception bit in MEM/WB.
REQ-016 SHALL implement FSM IDLE, REQ, RESP, DRAIN; reset state IDLE.
REQ-017 In IDLE/REQ with a valid, aligned, unflushed access, it SHALL drive dbus_read or dbus_write combinationally, with address, byteenable and writedata stable until dbus_waitrequest=0.
REQ-018 A request is accepted on a cycle with dbus_waitrequest=0; on a store the stage completes that cycle; on a load the FSM moves to RESP.
REQ-019 While the request is pending, the FSM SHALL be in REQ (entered from IDLE when waitrequest=1).
REQ-020 In RESP the stage SHALL complete on dbus_readdatavalid=1, then return to IDLE; minimum load latency is 2 cycles (1 stall cycle).
REQ-021 Load data SHALL be selected by addr[1:0] and extended by size and bit[2] to DATA_W; for non-loads reg_writedata SHALL equal alu_out.
REQ-022 Byteenable SHALL be 0001<<a (byte), 0011<<a (half), 1111 (word); writedata SHALL replicate the byte or half into every lane.
REQ-023 mem_stall_req SHALL be 1 in REQ, in RESP until readdatavalid, in DRAIN, and in IDLE while a load or a waitrequest-blocked store is presented.
REQ-024 MEM/WB SHALL load stage results on completion; non-memory instructions complete in one cycle; during a stall a bubble (valid=0) SHALL be written.
REQ-025 On mem_flush in IDLE/REQ, the stage SHALL drop the request and write a bubble.
REQ-026 On mem_flush in RESP, the FSM SHALL go to DRAIN and discard the next readdatavalid, then return to IDLE; it SHALL never leave a response orphaned.
REQ-027 A readdatavalid arriving in IDLE or REQ SHALL be ignored.

Reset
REQ-028 On rst the SHALL be: FSM=IDLE; dbus_read=0, dbus_write=0, mem_stall_req=0; mem2wb ctrl and exc = 0. MEM/WB data is not reset.
REQ-029 rst mid-transaction SHALL abandon the transaction without draining.

Structure
REQ-030 mem2wb_pipeline_{ctrl,exc,data}_t, the mem_opcode field constants and the FSM state enum SHALL live in the shared core package (core.svh).
REQ-031 Lane logic (byteenable, store replication, load extraction/extension) SHALL be one combinational sub-module, lsu_align.

Verification
REQ-032 LW addr 0x100, waitrequest=0, readdatavalid 1 cycle later with 0xDEADBEEF -> one stall cycle, reg_writedata=0xDEADBEEF.
REQ-033 LB addr 0x103, readdata 0x80112233 -> byteenable 1000, reg_writedata 0xFFFFFF80; LBU -> 0x00000080.
REQ-034 SH addr 0x202 data 0x0000ABCD, waitrequest high 3 cycles -> request held stable; byteenable 1100; writedata 0xABCDABCD; 3 stall cycles.
REQ-035 LW addr 0x101 -> no dbus_read, exception_load_addr_misaligned=1, no stall.
REQ-036 LW accepted, mem_flush in RESP, readdatavalid 2 cycles later -> DRAIN, data discarded, MEM/WB bubble, stall released after readdatavalid.
REQ-037 rst asserted in RESP -> next cycle IDLE, all strobes 0, mem2wb ctrl 0.
